// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I-subset IDs, opcodes, function codes and encoder state type.
package riscv_pkg;
  localparam int WORD_SIZE = 32;
  localparam logic [4:0] INSTR_ID_NULL = 5'd0;
  localparam logic [4:0] INSTR_ID_ADD  = 5'd1;
  localparam logic [4:0] INSTR_ID_SUB  = 5'd2;
  localparam logic [4:0] INSTR_ID_XOR  = 5'd3;
  localparam logic [4:0] INSTR_ID_OR   = 5'd4;
  localparam logic [4:0] INSTR_ID_AND  = 5'd5;
  localparam logic [4:0] INSTR_ID_SLL  = 5'd6;
  localparam logic [4:0] INSTR_ID_SRL  = 5'd7;
  localparam logic [4:0] INSTR_ID_SRA  = 5'd8;
  localparam logic [4:0] INSTR_ID_SLT  = 5'd9;
  localparam logic [4:0] INSTR_ID_ADDI = 5'd10;
  localparam logic [4:0] INSTR_ID_XORI = 5'd11;
  localparam logic [4:0] INSTR_ID_ORI  = 5'd12;
  localparam logic [4:0] INSTR_ID_ANDI = 5'd13;
  localparam logic [4:0] INSTR_ID_SLLI = 5'd14;
  localparam logic [4:0] INSTR_ID_SRLI = 5'd15;
  localparam logic [4:0] INSTR_ID_SRAI = 5'd16;
  localparam logic [4:0] INSTR_ID_LW   = 5'd17;
  localparam logic [4:0] INSTR_ID_SW   = 5'd18;
  localparam logic [4:0] INSTR_ID_JAL  = 5'd19;
  localparam logic [3:0] ALU_CTRL_ADD = 4'd0;
  localparam logic [3:0] ALU_CTRL_SUB = 4'd1;
  localparam logic [3:0] ALU_CTRL_XOR = 4'd2;
  localparam logic [3:0] ALU_CTRL_OR  = 4'd3;
  localparam logic [3:0] ALU_CTRL_AND = 4'd4;
  localparam logic [3:0] ALU_CTRL_SLL = 4'd5;
  localparam logic [3:0] ALU_CTRL_SRL = 4'd6;
  localparam logic [3:0] ALU_CTRL_SRA = 4'd7;
  localparam logic [3:0] ALU_CTRL_SLT = 4'd8;
  localparam logic [6:0] OPC_REG   = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef enum logic [1:0] {ST_IDLE, ST_ENCODE, ST_OUT} enc_state_e;
endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational field packing and legality check for one request.
module instr_field_packer
  import riscv_pkg::*;
(
  input  logic [4:0]           id_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [31:0]          imm_i,
  output logic [WORD_SIZE-1:0] word_o,
  output logic                 illegal_o
);
  logic r_t, i_t, sh_t, lw_t, sw_t, jal_t, imm12_ok, shamt_ok, jal_ok;
  logic [2:0] f3;
  logic [6:0] f7;
  always_comb begin
    r_t   = id_i >= INSTR_ID_ADD && id_i <= INSTR_ID_SLT;
    i_t   = id_i >= INSTR_ID_ADDI && id_i <= INSTR_ID_ANDI;
    sh_t  = id_i >= INSTR_ID_SLLI && id_i <= INSTR_ID_SRAI;
    lw_t  = id_i == INSTR_ID_LW;
    sw_t  = id_i == INSTR_ID_SW;
    jal_t = id_i == INSTR_ID_JAL;
    // sign-extension checks: upper bits all equal means the value fits the field
    imm12_ok = &imm_i[31:11] || ~|imm_i[31:11];
    shamt_ok = ~|imm_i[31:5];
    jal_ok   = (&imm_i[31:20] || ~|imm_i[31:20]) && !imm_i[0];
    f7 = (id_i == INSTR_ID_SUB || id_i == INSTR_ID_SRA || id_i == INSTR_ID_SRAI) ? F7_ALT : F7_BASE;
    f3 = F3_ADD;
    case (id_i)
      INSTR_ID_SLL, INSTR_ID_SLLI:                            f3 = F3_SLL;
      INSTR_ID_SLT, INSTR_ID_LW, INSTR_ID_SW:                 f3 = F3_SLT;
      INSTR_ID_XOR, INSTR_ID_XORI:                            f3 = F3_XOR;
      INSTR_ID_SRL, INSTR_ID_SRA, INSTR_ID_SRLI, INSTR_ID_SRAI: f3 = F3_SR;
      INSTR_ID_OR, INSTR_ID_ORI:                              f3 = F3_OR;
      INSTR_ID_AND, INSTR_ID_ANDI:                            f3 = F3_AND;
      default:                                                f3 = F3_ADD;
    endcase
    word_o = r_t   ? {f7, rs2_i, rs1_i, f3, rd_i, OPC_REG} :
             i_t   ? {imm_i[11:0], rs1_i, f3, rd_i, OPC_IMM} :
             sh_t  ? {f7, imm_i[4:0], rs1_i, f3, rd_i, OPC_IMM} :
             lw_t  ? {imm_i[11:0], rs1_i, F3_LW, rd_i, OPC_LOAD} :
             sw_t  ? {imm_i[11:5], rs2_i, rs1_i, F3_LW, imm_i[4:0], OPC_STORE} :
             jal_t ? {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL} :
                     '0;
    illegal_o = !(r_t || i_t || sh_t || lw_t || sw_t || jal_t) ||
                ((i_t || lw_t || sw_t) && !imm12_ok) ||
                (sh_t && !shamt_ok) || (jal_t && !jal_ok);
  end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: handshake FSM that turns encode requests into addressed instruction words.
module instruction_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 In_valid,
  output logic                 In_ready,
  input  logic [4:0]           Instr_id,
  input  logic [4:0]           Rd,
  input  logic [4:0]           Rs1,
  input  logic [4:0]           Rs2,
  input  logic [31:0]          Imm,
  output logic                 Out_valid,
  input  logic                 Out_ready,
  output logic [WORD_SIZE-1:0] Instr,
  output logic [ADDR_W-1:0]    Addr,
  output logic                 Err
);
  enc_state_e state_q, state_d;
  logic [4:0] id_q, rd_q, rs1_q, rs2_q;
  logic [31:0] imm_q;
  logic [WORD_SIZE-1:0] instr_q, word;
  logic [ADDR_W-1:0] addr_q;
  logic err_q, illegal;
  instr_field_packer u_packer (
    .id_i(id_q), .rd_i(rd_q), .rs1_i(rs1_q), .rs2_i(rs2_q), .imm_i(imm_q),
    .word_o(word), .illegal_o(illegal)
  );
  always_comb begin
    state_d = state_q == ST_IDLE   ? (In_valid ? ST_ENCODE : ST_IDLE) :
              state_q == ST_ENCODE ? (illegal ? ST_IDLE : ST_OUT) :
                                     (Out_ready ? ST_IDLE : ST_OUT);
    In_ready  = state_q == ST_IDLE;
    Out_valid = state_q == ST_OUT;
    Instr     = instr_q;
    Addr      = addr_q;
    Err       = err_q;
  end
  always_ff @(posedge Clk) begin
    if (In_ready && In_valid) begin
      id_q  <= Instr_id;
      rd_q  <= Rd;
      rs1_q <= Rs1;
      rs2_q <= Rs2;
      imm_q <= Imm;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= state_q == ST_ENCODE && illegal;
      if (state_q == ST_ENCODE && !illegal) instr_q <= word;
      if (Out_valid && Out_ready) addr_q <= addr_q + ADDR_W'(4);
    end
  end
endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Sequential encoder for the core's RV32I subset: the inverse of the instruction decoder. It accepts an instruction ID, register indices and an immediate over a valid/ready handshake, and packs them into a 32-bit instruction word. Each legal word is presented with an auto-incrementing byte address. It sits between the test-program generator / boot loader and the instruction memory write port, and rejects requests it cannot encode.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first emitted word.
- `ADDR_W`, default 32: width of `Addr`.
- `Clk`  in  1: clock.
- `Rst`  in  1: synchronous, active-high reset.
- `In_valid`  in  1: request present.
- `In_ready`  out  1: encoder can accept a request.
- `Instr_id`  in  5: instruction ID using the same encoding the decoder emits (1=ADD … 19=JAL, 0=NULL).
- `Rd`, `Rs1`, `Rs2`  in  5 each: register indices.
- `Imm`  in  32: signed immediate; shift amount for SLLI/SRLI/SRAI.
- `Out_valid`  out  1: encoded word available.
- `Out_ready`  in  1: consumer accepts the word.
- `Instr`  out  `WORD_SIZE`: encoded instruction.
- `Addr`  out  `ADDR_W`: byte address for `Instr`.
- `Err`  out  1: one-cycle pulse when a request is rejected.

## Operation
- States:
  - ST_IDLE: `In_ready`=1. On `In_valid`, register all inputs and go to ST_ENCODE.
  - ST_ENCODE: pack the fields, check legality, and register the result into `Instr`.
    - Illegal request: pulse `Err` and return to ST_IDLE.
    - Legal request: go to ST_OUT.
  - ST_OUT: `Out_valid`=1. On `Out_ready`, `Addr` += 4 and go to ST_IDLE.
- Formats:
  - R-type (ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT): funct7|rs2|rs1|funct3|rd|0110011.
  - I-type (ADDI, XORI, ORI, ANDI): imm[11:0]|rs1|funct3|rd|0010011.
  - Shifts (SLLI, SRLI, SRAI): funct7|shamt[4:0]|rs1|funct3|rd|0010011.
  - LW: imm[11:0]|rs1|010|rd|0000011.
  - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
- funct3 values: ADD/SUB 000, SLL 001, SLT 010, XOR 100, SRL/SRA 101, OR 110, AND 111.
- funct7 values: 0100000 for SUB, SRA and SRAI; 0000000 otherwise.
- Unused register fields are ignored (not forced to zero in the check).
- Legality, where any violation means reject:
  - `Instr_id` must be in 1..19.
  - I-type, LW and SW immediates must be in [-2048, 2047].
  - Shift amounts must be in [0, 31].
  - JAL immediate must be in [-2^20, 2^20-2] and even.
- `Addr` advances only on a completed output handshake. A rejected request consumes no address.
- `Addr` wraps modulo 2^`ADDR_W` silently.

## Timing
- Reset values: `In_ready`=1, `Out_valid`=0, `Err`=0, `Instr`=0, `Addr`=`BASE_ADDR`, state ST_IDLE.
- Request accepted at edge N:
  - `Out_valid` is high from cycle N+2, or
  - `Err` is high for cycle N+2 only.
- Minimum three cycles per instruction. There is no overlap of accept and output.
- `In_ready` is low in ST_ENCODE and ST_OUT. `In_valid` is ignored there.
- In ST_OUT, `Instr` and `Addr` are held stable until `Out_ready`. `Out_ready` high before `Out_valid` has no effect.
- The `Addr` increment is visible the cycle after the handshake. `In_ready` returns the same cycle.
- `Rst` in any state:
  - Discards any pending word.
  - Restores `Addr`=`BASE_ADDR`.
  - Reset wins over a simultaneous handshake.

## Structure
- Shared package `riscv_pkg` holds:
  - `INSTR_ID_*` and `ALU_CTRL_*` constants;
  - opcode, funct3 and funct7 constants;
  - state enum type.
- The decoder migrates its localparams to the same package.
- Sub-module `instr_field_packer`: purely combinational; takes ID, registers and Imm, returns {word, illegal}. The FSM, address counter and handshake stay in `instruction_encoder`.

## Test plan
- ADD rd=3 rs1=1 rs2=2 after reset -> `Instr`=0x002081B3, `Addr`=0x0, `Out_valid` two cycles after accept.
- ADDI rd=1 rs1=0 Imm=-1, then SRAI rd=5 rs1=6 Imm=3 -> 0xFFF00093 at 0x0, then 0x40335293 at 0x4.
- SW rs2=2 rs1=1 Imm=8, then JAL rd=1 Imm=8 -> 0x0020A423 at 0x0, then 0x008000EF at 0x4.
- ADDI Imm=2048; JAL Imm=7; `Instr_id`=0 -> `Err` pulses once each, no `Out_valid`; the next legal instruction still emits at 0x0.
- `Out_ready` held low for 5 cycles in ST_OUT -> `Instr`, `Addr` and `Out_valid` stable; `In_ready`=0; after the handshake `Addr`=0x4.
- `Rst` asserted in ST_OUT with `Out_ready`=1 -> no handshake counted; `Out_valid`=0 and `Addr`=`BASE_ADDR` next cycle.
